// File: rtl/lag_meter_if.sv
// Result handshake between lag_meter and its consumer (measurement
// accumulator / UI logic).
//   result        measured cycle count, all-ones on timeout
//   result_valid  result available, held until accepted
//   result_ready  consumer accepts result
//   timeout       qualifies result: measurement timed out
interface lag_meter_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [CNT_WIDTH-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 timeout;

    modport master (
        output result,
        output result_valid,
        output timeout,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        input  timeout,
        output result_ready
    );
endinterface

// File: rtl/lag_meter.sv
// Display-lag meter. Watches the delayed test-pattern video stream and arms
// after a fully dark frame. It then counts pixel clocks from the first white
// pixel of the flash until the debounced photo-sensor reports light.
// The count is not compensated for the fixed 2+DEBOUNCE cycle pipeline of the
// sensor path.
// Ports:
//   clock      pixel clock, shared with the video generator
//   reset      synchronous, active-high
//   de         data enable from the generator output
//   vsync      vsync from the generator output
//   vsync_pol  active level of vsync
//   red/green/blue  pixel colour
//   sensor_in  asynchronous photo-sensor level, high = light
//   res        result handshake (lag_meter_if master)
//   busy       high while ARMED or MEASURE
module lag_meter #(
    parameter int unsigned          CNT_WIDTH      = 32,
    parameter logic [7:0]           WHITE_THRESH   = 8'd200,
    parameter int unsigned          DEBOUNCE       = 4,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(148_500_000)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        de,
    input  logic        vsync,
    input  logic        vsync_pol,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        sensor_in,
    lag_meter_if.master res,
    output logic        busy
);

    localparam int unsigned      DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, HOLD} state_t;

    state_t state, state_next;

    logic                 s1, s2, db;
    logic [DB_W-1:0]      db_cnt;
    logic                 vs_prev;
    logic                 frame_seen, frame_has_white;
    logic                 white, boundary;
    logic [CNT_WIDTH-1:0] count;

    // ---------------- sensor conditioning ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db     <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= sensor_in;
            s2 <= s1;
            // db changes only after DEBOUNCE consecutive differing samples
            if (s2 != db) begin
                if (db_cnt == DB_LAST) begin
                    db     <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // ---------------- video observation ----------------
    assign white    = de && (red >= WHITE_THRESH) && (green >= WHITE_THRESH)
                         && (blue >= WHITE_THRESH);
    assign boundary = (vsync == vsync_pol) && (vs_prev != vsync_pol);

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_prev         <= ~vsync_pol;
            frame_seen      <= 1'b0;
            frame_has_white <= 1'b0;
        end else begin
            vs_prev <= vsync;
            if (boundary) begin
                frame_seen      <= 1'b1;
                // a white pixel on the boundary cycle belongs to the new frame
                frame_has_white <= white;
            end else if (white) begin
                frame_has_white <= 1'b1;
            end
        end
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (boundary && frame_seen && !frame_has_white && !db)
                         state_next = ARMED;
            ARMED:   if (white)   state_next = MEASURE;
                     else if (db) state_next = IDLE;
            MEASURE: if (db || count == TIMEOUT_CYCLES) state_next = HOLD;
            HOLD:    if (res.result_valid && res.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- counter and result registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count            <= '0;
            res.result       <= '0;
            res.result_valid <= 1'b0;
            res.timeout      <= 1'b0;
            busy             <= 1'b0;
        end else begin
            busy <= (state_next == ARMED) || (state_next == MEASURE);
            case (state)
                ARMED: if (white) count <= CNT_WIDTH'(1);
                MEASURE: begin
                    // sensor wins over timeout in the same cycle
                    if (db) begin
                        res.result       <= count;
                        res.timeout      <= 1'b0;
                        res.result_valid <= 1'b1;
                    end else if (count == TIMEOUT_CYCLES) begin
                        res.result       <= '1;
                        res.timeout      <= 1'b1;
                        res.result_valid <= 1'b1;
                    end else begin
                        count <= count + CNT_WIDTH'(1);
                    end
                end
                HOLD: if (res.result_valid && res.result_ready)
                          res.result_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_meter.sv
// Directed bench for lag_meter. Two instances share the stimulus: u_a with a
// long timeout for normal measurements, u_b with TIMEOUT_CYCLES=1000.
module tb_lag_meter;

    logic       clock = 1'b0;
    logic       reset;
    logic       de, vsync, vsync_pol;
    logic [7:0] red, green, blue;
    logic       sensor_in;
    logic       busy_a, busy_b;

    int tests = 0;
    int fails = 0;
    int elapsed;
    int n;
    bit ok;

    always #5 clock = ~clock;

    lag_meter_if #(.CNT_WIDTH(32)) bus_a ();
    lag_meter_if #(.CNT_WIDTH(32)) bus_b ();

    lag_meter #(.CNT_WIDTH(32), .WHITE_THRESH(8'd200), .DEBOUNCE(4),
                .TIMEOUT_CYCLES(32'd100_000)) u_a (
        .clock(clock), .reset(reset), .de(de), .vsync(vsync),
        .vsync_pol(vsync_pol), .red(red), .green(green), .blue(blue),
        .sensor_in(sensor_in), .res(bus_a.master), .busy(busy_a));

    lag_meter #(.CNT_WIDTH(32), .WHITE_THRESH(8'd200), .DEBOUNCE(4),
                .TIMEOUT_CYCLES(32'd1000)) u_b (
        .clock(clock), .reset(reset), .de(de), .vsync(vsync),
        .vsync_pol(vsync_pol), .red(red), .green(green), .blue(blue),
        .sensor_in(sensor_in), .res(bus_b.master), .busy(busy_b));

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic drive_idle;
        de = 1'b0; vsync = ~vsync_pol; red = 8'd0; green = 8'd0; blue = 8'd0;
    endtask

    task automatic do_reset;
        drive_idle();
        sensor_in = 1'b0;
        bus_a.result_ready = 1'b0;
        bus_b.result_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // single-cycle active vsync; caller samples state after the boundary edge
    task automatic frame_start;
        de = 1'b0; vsync = vsync_pol;
        tick();
        vsync = ~vsync_pol;
    endtask

    // near-threshold dark pixels (blue 199); optional exact-threshold white;
    // a white-level value with de low must not count
    task automatic frame_pixels(input bit with_white);
        for (int i = 0; i < 16; i++) begin
            de = 1'b1;
            if (with_white && i == 8) begin
                red = 8'd200; green = 8'd200; blue = 8'd200;
            end else begin
                red = 8'd250; green = 8'd250; blue = 8'd199;
            end
            tick();
        end
        de = 1'b0; red = 8'd255; green = 8'd255; blue = 8'd255;
        tick();
        red = 8'd0; green = 8'd0; blue = 8'd0;
        tick();
    endtask

    task automatic arm;
        frame_start();
        frame_pixels(1'b0);
        frame_start();
    endtask

    // white pixel sampled at edge w; elapsed counts edges after w
    task automatic flash;
        de = 1'b1; red = 8'd255; green = 8'd255; blue = 8'd255;
        tick();
        de = 1'b0; red = 8'd0; green = 8'd0; blue = 8'd0;
        elapsed = 0;
    endtask

    task automatic advance_to(input int target);
        while (elapsed < target) begin
            tick();
            elapsed++;
        end
    endtask

    task automatic wait_valid_a(input int limit, output int cycles);
        cycles = 0;
        while (bus_a.result_valid !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        vsync_pol = 1'b1;
        do_reset();
        tests++; if (bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus_a.result_valid); end
        tests++; if (bus_a.result !== 32'd0) begin fails++; $display("FAIL reset_result got %0d want 0", bus_a.result); end
        tests++; if (bus_a.timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", bus_a.timeout); end
        tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy got %b%b want 00", busy_a, busy_b); end
    endtask

    task automatic test_basic;
        do_reset();
        frame_start();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL first_boundary_busy got %b want 0", busy_a); end
        frame_pixels(1'b0);
        frame_start();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_armed got %b want 1", busy_a); end
        flash();
        advance_to(999);
        sensor_in = 1'b1;
        wait_valid_a(20, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL basic_latency got %0d want 7", n); end
        tests++; if (bus_a.result !== 32'd1006) begin fails++; $display("FAIL basic_result got %0d want 1006", bus_a.result); end
        tests++; if (bus_a.timeout !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL basic_flags timeout=%b busy=%b want 0 0", bus_a.timeout, busy_a); end
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sensor_in = i[2];
            tick();
            if (bus_a.result_valid !== 1'b1 || bus_a.result !== 32'd1006 || busy_a !== 1'b0) ok = 1'b0;
        end
        sensor_in = 1'b0;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_hold got unstable want valid=1 result=1006"); end
        bus_a.result_ready = 1'b1;
        tick();
        bus_a.result_ready = 1'b0;
        tests++; if (bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL basic_accept_valid got %b want 0", bus_a.result_valid); end
        tests++; if (bus_a.result !== 32'd1006 || bus_a.timeout !== 1'b0) begin fails++; $display("FAIL basic_after_accept result=%0d timeout=%b want 1006 0", bus_a.result, bus_a.timeout); end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid;
        drive_idle();
        sensor_in = 1'b0;
        arm();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL mid_armed got %b want 1", busy_a); end
        flash();
        advance_to(50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy_a !== 1'b0 || bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL mid_reset busy=%b valid=%b want 0 0", busy_a, bus_a.result_valid); end
        tests++; if (bus_a.result !== 32'd0) begin fails++; $display("FAIL mid_reset_result got %0d want 0", bus_a.result); end
        frame_start();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_first_boundary got %b want 0", busy_a); end
        frame_pixels(1'b0);
        frame_start();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL mid_rearm got %b want 1", busy_a); end
    endtask

    task automatic test_glitch;
        do_reset();
        arm();
        flash();
        advance_to(100);
        sensor_in = 1'b1;
        advance_to(103);
        sensor_in = 1'b0;
        advance_to(130);
        tests++; if (bus_a.result_valid !== 1'b0 || busy_a !== 1'b1) begin fails++; $display("FAIL glitch_ignored valid=%b busy=%b want 0 1", bus_a.result_valid, busy_a); end
        advance_to(499);
        sensor_in = 1'b1;
        wait_valid_a(20, n);
        tests++; if (bus_a.result_valid !== 1'b1 || bus_a.result !== 32'd506) begin fails++; $display("FAIL glitch_result got valid=%b result=%0d want 1 506", bus_a.result_valid, bus_a.result); end
        sensor_in = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset();
        arm();
        tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL to_armed got %b want 1", busy_b); end
        flash();
        advance_to(999);
        tests++; if (bus_b.result_valid !== 1'b0 || busy_b !== 1'b1) begin fails++; $display("FAIL to_early valid=%b busy=%b want 0 1", bus_b.result_valid, busy_b); end
        advance_to(1000);
        tests++; if (bus_b.result_valid !== 1'b1) begin fails++; $display("FAIL to_valid got %b want 1", bus_b.result_valid); end
        tests++; if (bus_b.result !== 32'hFFFF_FFFF || bus_b.timeout !== 1'b1 || busy_b !== 1'b0) begin fails++; $display("FAIL to_result result=%h timeout=%b busy=%b want ffffffff 1 0", bus_b.result, bus_b.timeout, busy_b); end
    endtask

    task automatic test_stray_light;
        do_reset();
        arm();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL stray_armed got %b want 1", busy_a); end
        sensor_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL stray_early got %b want 1", busy_a); end
        tick();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL stray_disarm got %b want 0", busy_a); end
        flash();
        advance_to(20);
        tests++; if (busy_a !== 1'b0 || bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL stray_no_result busy=%b valid=%b want 0 0", busy_a, bus_a.result_valid); end
        sensor_in = 1'b0;
    endtask

    task automatic test_all_white;
        do_reset();
        frame_start();
        frame_pixels(1'b1);
        frame_start();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL white_frame1 got %b want 0", busy_a); end
        frame_pixels(1'b1);
        frame_start();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL white_frame2 got %b want 0", busy_a); end
        flash();
        tests++; if (busy_a !== 1'b0 || bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL white_flash busy=%b valid=%b want 0 0", busy_a, bus_a.result_valid); end
    endtask

    task automatic test_pol_low;
        vsync_pol = 1'b0;
        do_reset();
        frame_start();
        frame_pixels(1'b0);
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL pol0_before got %b want 0", busy_a); end
        frame_start();
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL pol0_armed got %b want 1", busy_a); end
        flash();
        advance_to(999);
        sensor_in = 1'b1;
        wait_valid_a(20, n);
        tests++; if (bus_a.result_valid !== 1'b1 || bus_a.result !== 32'd1006 || bus_a.timeout !== 1'b0) begin fails++; $display("FAIL pol0_result valid=%b result=%0d timeout=%b want 1 1006 0", bus_a.result_valid, bus_a.result, bus_a.timeout); end
        sensor_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_glitch();
        test_timeout();
        test_stray_light();
        test_all_white();
        test_pol_low();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/lag_meter.md
Name: lag_meter

Overview:
- Downstream consumer of the test-pattern video generator's delayed output stream (de, vsync, RGB).
- Detects the first white pixel of a flash after a fully dark frame, then counts clock cycles until the debounced photo-sensor input asserts.
- Presents the cycle count on a valid/ready result port for the measurement accumulator and UI logic.
- Sits beside the encoder tap, on the same pixel clock as the generator.

Parameters:
- CNT_WIDTH, 32: width of the cycle counter and the result.
- WHITE_THRESH, 8'd200: minimum R, G and B value for a pixel to count as white.
- DEBOUNCE, 4: number of consecutive differing synchronized samples (≥1) needed to change the debounced sensor state.
- TIMEOUT_CYCLES, 32'd148_500_000: counter value at which a measurement aborts.

Ports:
- clock  in  1  pixel clock, same as the video generator.
- reset  in  1  synchronous, active-high.
- de  in  1  data enable from the generator output.
- vsync  in  1  vsync from the generator output.
- vsync_pol  in  1  active level of vsync (the mode's v_sync_pol).
- red  in  8  pixel red.
- green  in  8  pixel green.
- blue  in  8  pixel blue.
- sensor_in  in  1  asynchronous photo-sensor level, high = light detected.
- result  out  CNT_WIDTH  measured cycle count; all-ones on timeout.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- timeout  out  1  qualifies result: measurement timed out.
- busy  out  1  high in ARMED or MEASURE.

Behaviour:
- Reset:
  - state IDLE; result=0, result_valid=0, timeout=0, busy=0.
  - Sync flops, debounced sensor and debounce count cleared.
  - frame_seen=0, frame_has_white=0.
  - Reset mid-measurement aborts without producing a result.
- Sensor conditioning:
  - 2-flop synchronizer s1→s2.
  - Each edge: if s2≠db, cnt<=cnt+1, and when cnt==DEBOUNCE-1 then db<=s2 and cnt<=0. Otherwise cnt<=0.
  - Consequence: sensor_in first sampled high at edge k makes db high after edge k+1+DEBOUNCE.
- White pixel: de && red≥WHITE_THRESH && green≥WHITE_THRESH && blue≥WHITE_THRESH, evaluated combinationally on the inputs.
- Frame boundary: cycle where vsync==vsync_pol and the previous-cycle vsync≠vsync_pol (registered previous sample, reset to ~vsync_pol-equivalent inactive).
  - frame_has_white is set by any white pixel and cleared at each boundary. A white pixel on the boundary cycle itself counts toward the new frame.
  - frame_seen is set at the first boundary.
- State machine:
  - IDLE → ARMED at a boundary when frame_seen && !frame_has_white (previous frame completely dark) && db==0.
  - ARMED:
    - white pixel → MEASURE with count<=1.
    - else if db==1 (stray light) → IDLE.
    - White pixel has priority when both occur in the same cycle.
  - MEASURE, each edge:
    - if db==1: result<=count, timeout<=0, result_valid<=1 → HOLD.
    - else if count==TIMEOUT_CYCLES: result<=all-ones, timeout<=1, result_valid<=1 → HOLD.
    - else count<=count+1.
    - Sensor has priority over timeout in the same cycle.
  - HOLD:
    - result, timeout and result_valid are held stable until result_valid && result_ready.
    - On that edge result_valid<=0 → IDLE; result and timeout keep their values.
    - Video and sensor activity in HOLD is ignored for state, but frame flags keep tracking.
  - busy=1 exactly in ARMED and MEASURE (registered with the state).
- Net formula: white pixel at edge w, sensor_in first sampled high at edge w+N gives result = N+2+DEBOUNCE. The result is not compensated; software subtracts 2+DEBOUNCE.
- Counter never wraps: TIMEOUT_CYCLES < 2^CNT_WIDTH-1 is required.
- Re-arm requires a new fully dark frame after returning to IDLE. A flash in progress cannot re-trigger.

Test Plan:
- Dark frame, then white pixel at edge w, sensor_in rises before edge w+1000; DEBOUNCE=4: result=1006, timeout=0, result_valid=1 held with result_ready=0 for 50 cycles, then cleared 1 cycle after ready.
- Sensor glitch high for 3 samples during MEASURE (DEBOUNCE=4): no result. A later stable rise at N=500 gives result=506.
- TIMEOUT_CYCLES=1000, sensor never rises: result_valid at edge w+1000, result=all-ones, timeout=1, busy=0.
- Sensor high before the flash (debounced while ARMED): returns to IDLE, no result. Every frame contains white: never leaves IDLE.
- reset asserted mid-MEASURE for 1 cycle: busy=0, result_valid=0, result=0. The next measurement only starts after a new full dark frame.
- vsync_pol=0 with active-low vsync: arming occurs on the falling vsync edge. A measurement identical to the first scenario also returns 1006.
